// File: rtl/display_pkg.sv
// -----------------------------------------------------------------------------
// display_pkg
// Shared definitions for the multiplexed seven-segment display scanner.
//   SEG_BLANK   : cathode pattern with every segment off (active-low).
//   GLYPH_TABLE : active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F,
//                 indexed directly by the nibble value.
//   nibble_t    : one hex digit as carried in the digit buffers.
// -----------------------------------------------------------------------------
package display_pkg;

  typedef logic [3:0] nibble_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Packed so that GLYPH_TABLE[n] selects the glyph for nibble n; the
  // concatenation is written from F down to 0.
  localparam logic [15:0][6:0] GLYPH_TABLE = {
    7'h0E,  // F
    7'h06,  // E
    7'h21,  // d
    7'h46,  // C
    7'h03,  // b
    7'h08,  // A
    7'h10,  // 9
    7'h00,  // 8
    7'h78,  // 7
    7'h02,  // 6
    7'h12,  // 5
    7'h19,  // 4
    7'h30,  // 3
    7'h24,  // 2
    7'h79,  // 1
    7'h40   // 0
  };

endpackage

// File: rtl/hex_to_7seg.sv
// -----------------------------------------------------------------------------
// hex_to_7seg
// Combinational hex-digit to seven-segment decoder.
// Ports:
//   nib : input  4-bit hex digit
//   seg : output 7-bit cathode pattern {g,f,e,d,c,b,a}, active-low
// -----------------------------------------------------------------------------
module hex_to_7seg
  import display_pkg::*;
(
  input  nibble_t    nib,
  output logic [6:0] seg
);

  assign seg = GLYPH_TABLE[nib];

endmodule

// File: rtl/display_scanner.sv
// -----------------------------------------------------------------------------
// display_scanner
// Time-multiplexed driver for an N_DIGITS common-anode seven-segment display.
// Each digit owns a slot of REFRESH_DIV clocks; the first GUARD clocks of a
// slot keep every anode off so the previous digit's pattern cannot ghost.
// Digit data is double buffered: load writes a pending buffer that is moved
// into the displayed (active) buffer only at the frame boundary.
// Ports:
//   clk         : input  system clock, rising edge
//   reset       : input  asynchronous active-high reset
//   digits_in   : input  4*N_DIGITS hex nibbles, nibble 0 is the rightmost digit
//   dp_in       : input  N_DIGITS decimal-point requests
//   load        : input  strobe capturing digits_in/dp_in into the pending buffer
//   blank_lz    : input  leading-zero blanking enable (used live)
//   an          : output N_DIGITS anode enables, active-low
//   seg         : output 7 cathodes {g,f,e,d,c,b,a}, active-low
//   dp          : output decimal-point cathode, active-low
//   scan_idx    : output index of the digit currently driven
//   frame_start : output one-cycle pulse when scan_idx returns to 0
// -----------------------------------------------------------------------------
module display_scanner
  import display_pkg::*;
#(
  parameter int N_DIGITS    = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [4*N_DIGITS-1:0]       digits_in,
  input  logic [N_DIGITS-1:0]         dp_in,
  input  logic                        load,
  input  logic                        blank_lz,
  output logic [N_DIGITS-1:0]         an,
  output logic [6:0]                  seg,
  output logic                        dp,
  output logic [$clog2(N_DIGITS)-1:0] scan_idx,
  output logic                        frame_start
);

  localparam int IDX_W = $clog2(N_DIGITS);
  localparam int CNT_W = $clog2(REFRESH_DIV);

  // Internal scan position
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  frame_tick_q, frame_tick_d;

  // Digit buffers
  logic [4*N_DIGITS-1:0] pend_q, pend_d;
  logic [N_DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic                  pend_valid_q, pend_valid_d;
  logic [4*N_DIGITS-1:0] act_q, act_d;
  logic [N_DIGITS-1:0]   act_dp_q, act_dp_d;

  // Registered pin drivers
  logic [N_DIGITS-1:0]   an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [IDX_W-1:0]      scan_idx_q, scan_idx_d;
  logic                  frame_start_q, frame_start_d;

  logic                  slot_end;
  logic                  frame_end;
  nibble_t               cur_nib;
  logic [6:0]            cur_glyph;
  logic [N_DIGITS-1:0]   lz_run;
  logic                  zero_run;
  logic                  lz_blank;

  // ---------------------------------------------------------------------------
  // Scan position: slot counter and digit index
  // ---------------------------------------------------------------------------
  always_comb begin
    slot_end     = (cnt_q == CNT_W'(REFRESH_DIV - 1));
    frame_end    = slot_end && (idx_q == IDX_W'(N_DIGITS - 1));
    cnt_d        = slot_end ? '0 : cnt_q + CNT_W'(1);
    idx_d        = idx_q;
    if (slot_end) begin
      idx_d = frame_end ? '0 : idx_q + IDX_W'(1);
    end
    // Marks the first internal cycle of a frame; delayed once more so the
    // pulse reaches the pin together with scan_idx returning to 0.
    frame_tick_d = frame_end;
  end

  // ---------------------------------------------------------------------------
  // Double buffer. The swap takes the pending contents as they stood before
  // this edge, so a load on the same edge lands in pending for the next frame.
  // ---------------------------------------------------------------------------
  always_comb begin
    pend_d       = pend_q;
    pend_dp_d    = pend_dp_q;
    pend_valid_d = pend_valid_q;
    act_d        = act_q;
    act_dp_d     = act_dp_q;
    if (frame_end && pend_valid_q) begin
      act_d        = pend_q;
      act_dp_d     = pend_dp_q;
      pend_valid_d = 1'b0;
    end
    if (load) begin
      pend_d       = digits_in;
      pend_dp_d    = dp_in;
      pend_valid_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Digit decode and leading-zero detection
  // ---------------------------------------------------------------------------
  assign cur_nib = act_q[4*idx_q +: 4];

  hex_to_7seg u_hex_to_7seg (
    .nib (cur_nib),
    .seg (cur_glyph)
  );

  // lz_run[i] is set when nibbles i..N_DIGITS-1 of the active buffer are all 0.
  always_comb begin
    zero_run = 1'b1;
    lz_run   = '0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      zero_run  = zero_run && (act_q[4*i +: 4] == 4'h0);
      lz_run[i] = zero_run;
    end
  end

  assign lz_blank = blank_lz && (idx_q != '0) && lz_run[idx_q];

  // ---------------------------------------------------------------------------
  // Pin drivers, one register stage after the scan position
  // ---------------------------------------------------------------------------
  always_comb begin
    an_d          = '1;
    seg_d         = SEG_BLANK;
    dp_d          = 1'b1;
    if (cnt_q >= CNT_W'(GUARD)) begin
      an_d  = ~(N_DIGITS'(1) << idx_q);
      seg_d = lz_blank ? SEG_BLANK : cur_glyph;
      dp_d  = ~act_dp_q[idx_q];
    end
    scan_idx_d    = idx_q;
    frame_start_d = frame_tick_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q         <= '0;
      idx_q         <= '0;
      frame_tick_q  <= 1'b0;
      pend_q        <= '0;
      pend_dp_q     <= '0;
      pend_valid_q  <= 1'b0;
      act_q         <= '0;
      act_dp_q      <= '0;
      an_q          <= '1;
      seg_q         <= SEG_BLANK;
      dp_q          <= 1'b1;
      scan_idx_q    <= '0;
      frame_start_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      frame_tick_q  <= frame_tick_d;
      pend_q        <= pend_d;
      pend_dp_q     <= pend_dp_d;
      pend_valid_q  <= pend_valid_d;
      act_q         <= act_d;
      act_dp_q      <= act_dp_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      scan_idx_q    <= scan_idx_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign an          = an_q;
  assign seg         = seg_q;
  assign dp          = dp_q;
  assign scan_idx    = scan_idx_q;
  assign frame_start = frame_start_q;

endmodule
